// File: rtl/alu_sequencer.sv
// alu_sequencer
//
// Control-unit side issuer for the logic_unit. Accepts one ALU, shift or
// branch request, drives the matching ALUOp sequence (including the
// load/settle cycles of the registered shifter), samples the logic unit
// flags at the right edge and returns a one-cycle done pulse with status.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   start        request strobe, honoured only while idle
//   req_op[3:0]  request code (0 ADD .. 12 BLE, 13-15 illegal)
//   ZERO         zero flag from the logic unit
//   OVERFLOW     overflow flag from the logic unit
//   Update_UC    branch-condition result from the logic unit
//   ALUOp[3:0]   registered operation code to the logic unit
//   busy         high in every state except IDLE
//   done         one-cycle completion pulse
//   alu_out_we   ALUOut write enable (valid with done)
//   branch_taken branch decision (valid with done)
//   zero_q       sampled ZERO (valid with done)
//   overflow_exc overflow exception (valid with done)
//   illegal_op   illegal request code (valid with done)

module alu_sequencer #(
  parameter logic [3:0] ALUOP_NOP  = 4'd0,
  parameter logic [3:0] ALUOP_ADD  = 4'd1,
  parameter logic [3:0] ALUOP_SUB  = 4'd2,
  parameter logic [3:0] ALUOP_AND  = 4'd3,
  parameter logic [3:0] ALUOP_SLT  = 4'd4,
  parameter logic [3:0] ALUOP_SHLD = 4'd5,
  parameter logic [3:0] ALUOP_SLL  = 4'd6,
  parameter logic [3:0] ALUOP_SRL  = 4'd7,
  parameter logic [3:0] ALUOP_SRA  = 4'd8,
  parameter logic [3:0] ALUOP_BEQ  = 4'd9,
  parameter logic [3:0] ALUOP_BNE  = 4'd10,
  parameter logic [3:0] ALUOP_BGT  = 4'd11,
  parameter logic [3:0] ALUOP_BLE  = 4'd12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] req_op,
  input  logic       ZERO,
  input  logic       OVERFLOW,
  input  logic       Update_UC,
  output logic [3:0] ALUOp,
  output logic       busy,
  output logic       done,
  output logic       alu_out_we,
  output logic       branch_taken,
  output logic       zero_q,
  output logic       overflow_exc,
  output logic       illegal_op
);

  // Request codes as seen from the control unit
  localparam logic [3:0] REQ_ADD  = 4'd0;
  localparam logic [3:0] REQ_ADDU = 4'd1;
  localparam logic [3:0] REQ_SUB  = 4'd2;
  localparam logic [3:0] REQ_SUBU = 4'd3;
  localparam logic [3:0] REQ_AND  = 4'd4;
  localparam logic [3:0] REQ_SLT  = 4'd5;
  localparam logic [3:0] REQ_SLL  = 4'd6;
  localparam logic [3:0] REQ_SRL  = 4'd7;
  localparam logic [3:0] REQ_SRA  = 4'd8;
  localparam logic [3:0] REQ_BEQ  = 4'd9;
  localparam logic [3:0] REQ_BNE  = 4'd10;
  localparam logic [3:0] REQ_BGT  = 4'd11;
  localparam logic [3:0] REQ_BLE  = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_SETTLE,
    S_RESP
  } state_t;

  state_t     state;
  logic [3:0] op_q;

  logic resp_ovf;
  logic resp_br;
  logic resp_we;

  // Translate a request code into the logic-unit operation it executes
  function automatic logic [3:0] exec_code(input logic [3:0] op);
    logic [3:0] code;
    case (op)
      REQ_ADD, REQ_ADDU: code = ALUOP_ADD;
      REQ_SUB, REQ_SUBU: code = ALUOP_SUB;
      REQ_AND:           code = ALUOP_AND;
      REQ_SLT:           code = ALUOP_SLT;
      REQ_SLL:           code = ALUOP_SLL;
      REQ_SRL:           code = ALUOP_SRL;
      REQ_SRA:           code = ALUOP_SRA;
      REQ_BEQ:           code = ALUOP_BEQ;
      REQ_BNE:           code = ALUOP_BNE;
      REQ_BGT:           code = ALUOP_BGT;
      REQ_BLE:           code = ALUOP_BLE;
      default:           code = ALUOP_NOP;
    endcase
    return code;
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op >= REQ_SLL) && (op <= REQ_SRA);
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op >= REQ_BEQ) && (op <= REQ_BLE);
  endfunction

  // Response status for the captured op, using the flags present on the
  // edge that enters RESP; only checked ADD/SUB raise an overflow exception
  always_comb begin
    resp_ovf = OVERFLOW && ((op_q == REQ_ADD) || (op_q == REQ_SUB));
    resp_br  = Update_UC && is_branch(op_q);
    resp_we  = (op_q <= REQ_SRA) && !resp_ovf;
  end

  // Sequencer FSM; every output is registered and the status outputs are
  // cleared by default so they can only be high during the done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      op_q         <= 4'd0;
      ALUOp        <= ALUOP_NOP;
      busy         <= 1'b0;
      done         <= 1'b0;
      alu_out_we   <= 1'b0;
      branch_taken <= 1'b0;
      zero_q       <= 1'b0;
      overflow_exc <= 1'b0;
      illegal_op   <= 1'b0;
    end else begin
      done         <= 1'b0;
      alu_out_we   <= 1'b0;
      branch_taken <= 1'b0;
      zero_q       <= 1'b0;
      overflow_exc <= 1'b0;
      illegal_op   <= 1'b0;

      case (state)
        S_IDLE: begin
          ALUOp <= ALUOP_NOP;
          if (start) begin
            op_q <= req_op;
            busy <= 1'b1;
            if (is_shift(req_op)) begin
              state <= S_LOAD;
              ALUOp <= ALUOP_SHLD;
            end else if (req_op > REQ_BLE) begin
              // Illegal codes answer immediately without touching the unit
              state      <= S_RESP;
              done       <= 1'b1;
              illegal_op <= 1'b1;
              zero_q     <= ZERO;
            end else begin
              state <= S_EXEC;
              ALUOp <= exec_code(req_op);
            end
          end
        end

        S_LOAD: begin
          state <= S_EXEC;
          ALUOp <= exec_code(op_q);
        end

        S_EXEC: begin
          if (is_shift(op_q)) begin
            // Shift code stays on ALUOp while the shifter settles
            state <= S_SETTLE;
          end else begin
            state        <= S_RESP;
            ALUOp        <= ALUOP_NOP;
            done         <= 1'b1;
            zero_q       <= ZERO;
            overflow_exc <= resp_ovf;
            branch_taken <= resp_br;
            alu_out_we   <= resp_we;
          end
        end

        S_SETTLE: begin
          state        <= S_RESP;
          ALUOp        <= ALUOP_NOP;
          done         <= 1'b1;
          zero_q       <= ZERO;
          overflow_exc <= resp_ovf;
          branch_taken <= resp_br;
          alu_out_we   <= resp_we;
        end

        S_RESP: begin
          state <= S_IDLE;
          ALUOp <= ALUOP_NOP;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          ALUOp <= ALUOP_NOP;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//
// Directed bench for alu_sequencer. Each request pushes its expected
// response onto a scoreboard queue; the entry is popped and compared when
// the done pulse appears. ALUOp is compared cycle by cycle against the
// sequence the logic unit should see. Flags from the logic unit are held
// constant for the duration of each request.

module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] req_op;
  logic       ZERO;
  logic       OVERFLOW;
  logic       Update_UC;
  logic [3:0] ALUOp;
  logic       busy;
  logic       done;
  logic       alu_out_we;
  logic       branch_taken;
  logic       zero_q;
  logic       overflow_exc;
  logic       illegal_op;

  typedef struct packed {
    logic we;
    logic br;
    logic zq;
    logic ovf;
    logic ill;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  alu_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .req_op       (req_op),
    .ZERO         (ZERO),
    .OVERFLOW     (OVERFLOW),
    .Update_UC    (Update_UC),
    .ALUOp        (ALUOp),
    .busy         (busy),
    .done         (done),
    .alu_out_we   (alu_out_we),
    .branch_taken (branch_taken),
    .zero_q       (zero_q),
    .overflow_exc (overflow_exc),
    .illegal_op   (illegal_op)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive a request for one edge and record what the response should be
  task automatic applyStimulus(input logic [3:0] op, input logic z, input logic ov, input logic uc);
    exp_t e;
    start     = 1'b1;
    req_op    = op;
    ZERO      = z;
    OVERFLOW  = ov;
    Update_UC = uc;
    e.ill = (op >= 4'd13);
    e.br  = (op >= 4'd9 && op <= 4'd12) ? uc : 1'b0;
    e.ovf = ov && (op == 4'd0 || op == 4'd2);
    e.we  = (op <= 4'd8) && !e.ovf;
    e.zq  = z;
    sb.push_back(e);
  endtask

  // Issue one request and follow it to completion; seq holds ALUOp for
  // the cycles before done, inject pulses start while the op is busy
  task automatic runOp(input string tag, input logic [3:0] op, input logic z, input logic ov,
                       input logic uc, input int lat, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [3:0] s2, input bit inject);
    logic [3:0] seq[3];
    exp_t e;
    int cyc;
    int extra;
    bit got;
    seq = '{s0, s1, s2};
    applyStimulus(op, z, ov, uc);
    tick();
    start = 1'b0;
    cyc = 1;
    got = 1'b0;
    while (!got && cyc <= 8) begin
      if (done) begin
        got = 1'b1;
        checkOutput({tag, "_latency"}, 8'(cyc), 8'(lat));
        checkOutput({tag, "_aluop_done"}, {4'd0, ALUOp}, 8'd0);
        e = sb.pop_front();
        checkOutput({tag, "_we"},  {7'd0, alu_out_we},   {7'd0, e.we});
        checkOutput({tag, "_br"},  {7'd0, branch_taken}, {7'd0, e.br});
        checkOutput({tag, "_zq"},  {7'd0, zero_q},       {7'd0, e.zq});
        checkOutput({tag, "_ovf"}, {7'd0, overflow_exc}, {7'd0, e.ovf});
        checkOutput({tag, "_ill"}, {7'd0, illegal_op},   {7'd0, e.ill});
      end else begin
        if (cyc <= 3) checkOutput({tag, "_aluop"}, {4'd0, ALUOp}, {4'd0, seq[cyc-1]});
        checkOutput({tag, "_busy"}, {7'd0, busy}, 8'd1);
        if (inject && cyc == 2) begin
          start  = 1'b1;
          req_op = 4'd1;
        end else begin
          start = 1'b0;
        end
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    checkOutput({tag, "_timeout"}, {7'd0, got}, 8'd1);
    if (!got) void'(sb.pop_front());
    tick();
    checkOutput({tag, "_idle_busy"}, {7'd0, busy}, 8'd0);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) extra++;
      if (i < 3) tick();
    end
    checkOutput({tag, "_no_extra_done"}, 8'(extra), 8'd0);
  endtask

  initial begin
    int dones;
    reset     = 1'b1;
    start     = 1'b0;
    req_op    = 4'd0;
    ZERO      = 1'b0;
    OVERFLOW  = 1'b0;
    Update_UC = 1'b0;
    tick();
    tick();
    checkOutput("reset_aluop", {4'd0, ALUOp}, 8'd0);
    checkOutput("reset_status",
                {3'd0, busy, done, alu_out_we, branch_taken, zero_q | overflow_exc | illegal_op},
                8'd0);
    reset = 1'b0;
    tick();

    runOp("add_ovf",  4'd0,  1'b0, 1'b1, 1'b0, 2, 4'd1, 4'd0, 4'd0, 1'b0);
    runOp("addu_ovf", 4'd1,  1'b0, 1'b1, 1'b0, 2, 4'd1, 4'd0, 4'd0, 1'b0);
    runOp("sub_zero", 4'd2,  1'b1, 1'b0, 1'b0, 2, 4'd2, 4'd0, 4'd0, 1'b0);
    runOp("subu_ovf", 4'd3,  1'b0, 1'b1, 1'b0, 2, 4'd2, 4'd0, 4'd0, 1'b0);
    runOp("and_ovf",  4'd4,  1'b0, 1'b1, 1'b1, 2, 4'd3, 4'd0, 4'd0, 1'b0);
    runOp("slt",      4'd5,  1'b1, 1'b0, 1'b1, 2, 4'd4, 4'd0, 4'd0, 1'b0);
    runOp("sra",      4'd8,  1'b1, 1'b0, 1'b0, 4, 4'd5, 4'd8, 4'd8, 1'b0);
    runOp("srl",      4'd7,  1'b0, 1'b0, 1'b0, 4, 4'd5, 4'd7, 4'd7, 1'b0);
    runOp("sll_busy", 4'd6,  1'b0, 1'b1, 1'b0, 4, 4'd5, 4'd6, 4'd6, 1'b1);
    runOp("beq_tkn",  4'd9,  1'b1, 1'b0, 1'b1, 2, 4'd9, 4'd0, 4'd0, 1'b0);
    runOp("bne_not",  4'd10, 1'b0, 1'b0, 1'b0, 2, 4'd10, 4'd0, 4'd0, 1'b0);
    runOp("bgt_tkn",  4'd11, 1'b0, 1'b1, 1'b1, 2, 4'd11, 4'd0, 4'd0, 1'b0);
    runOp("ble_tkn",  4'd12, 1'b1, 1'b0, 1'b1, 2, 4'd12, 4'd0, 4'd0, 1'b0);
    runOp("illegal",  4'd14, 1'b0, 1'b1, 1'b1, 1, 4'd0, 4'd0, 4'd0, 1'b0);

    // Reset while the shifter is settling: the request is aborted silently
    applyStimulus(4'd8, 1'b0, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("settle_aluop", {4'd0, ALUOp}, 8'd8);
    reset = 1'b1;
    tick();
    void'(sb.pop_front());
    reset = 1'b0;
    checkOutput("midrst_busy",  {7'd0, busy}, 8'd0);
    checkOutput("midrst_aluop", {4'd0, ALUOp}, 8'd0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) dones++;
      tick();
    end
    checkOutput("midrst_no_done", 8'(dones), 8'd0);
    runOp("add_after_rst", 4'd0, 1'b0, 1'b0, 1'b0, 2, 4'd1, 4'd0, 4'd0, 1'b0);

    // start together with reset is dropped
    start  = 1'b1;
    req_op = 4'd0;
    reset  = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    checkOutput("start_rst_busy",  {7'd0, busy}, 8'd0);
    checkOutput("start_rst_aluop", {4'd0, ALUOp}, 8'd0);
    tick();
    checkOutput("start_rst_done", {7'd0, done}, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
